// File: rtl/i2c_pkg.sv
// Shared I2C master definitions.
// Holds the SCL phase-FSM state encoding (3 bits, IDLE = 0) and the default
// depth of the pad-input synchronisers used by the SCL/SDA front ends.
package i2c_pkg;

  localparam int SYNC_STAGES_DEF = 2;

  typedef logic [2:0] scl_state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOW_A  = 3'd1;
  localparam logic [2:0] ST_LOW_B  = 3'd2;
  localparam logic [2:0] ST_HIGH_A = 3'd3;
  localparam logic [2:0] ST_HIGH_B = 3'd4;

endpackage

// File: rtl/i2c_sync.sv
// N-stage level synchroniser for an asynchronous pad input.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset; the chain clears to 0
//   d     in  asynchronous level
//   q     out synchronised level, STAGES cycles behind d
module i2c_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/i2c_scl_gen.sv
// I2C SCL generator: four equal quarter phases per SCL period from a runtime
// divider, open-drain drive, slave clock stretching with timeout and
// multi-master synchronisation (an early external low ends the high phase).
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   enable           1 = run SCL; 0 = finish the current period then idle
//   div              quarter-phase length minus 1 (captured at each LOW_A entry)
//   scl_in           raw SCL pad level (asynchronous)
//   scl_oe           1 = pull SCL low, 0 = release
//   fall_tick        pulse in the first LOW_A cycle (period start)
//   change_tick      pulse in the first LOW_B cycle (SDA may change)
//   rise_tick        pulse when SCL is first seen high after release
//   sample_tick      pulse in the first HIGH_B cycle (sample SDA)
//   stretching       released but synchronised SCL still low
//   stretch_timeout  pulse when the stretch limit is hit; FSM then idles
//   busy             FSM not in IDLE
module i2c_scl_gen
  import i2c_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int STRETCH_MAX = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  input  logic             scl_in,
  output logic             scl_oe,
  output logic             fall_tick,
  output logic             change_tick,
  output logic             rise_tick,
  output logic             sample_tick,
  output logic             stretching,
  output logic             stretch_timeout,
  output logic             busy
);

  localparam int SW = (STRETCH_MAX > 0) ? $clog2(STRETCH_MAX + 1) : 1;
  localparam bit TIMEOUT_EN = (STRETCH_MAX != 0);
  localparam logic [SW-1:0]    STRETCH_LIM = SW'(STRETCH_MAX);
  localparam logic [SW-1:0]    ST_ONE      = SW'(1);
  localparam logic [DIV_W-1:0] CNT_ONE     = DIV_W'(1);

  scl_state_t       state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic [SW-1:0]    stretch_cnt;
  logic             high_seen;
  logic             scl_sync;
  logic             cnt_done;

  i2c_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (scl_in),
    .q     (scl_sync)
  );

  // high_seen separates "waiting for the bus to rise" from "timing the high
  // quarter" inside HIGH_A; the synchroniser latency is part of the wait.
  always_comb begin
    cnt_done        = (cnt == div_q);
    busy            = (state != ST_IDLE);
    rise_tick       = (state == ST_HIGH_A) && !high_seen && scl_sync;
    stretching      = (state == ST_HIGH_A) && !high_seen && !scl_sync;
    stretch_timeout = TIMEOUT_EN && stretching && (stretch_cnt == STRETCH_LIM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      div_q       <= '0;
      stretch_cnt <= '0;
      high_seen   <= 1'b0;
      scl_oe      <= 1'b0;
      fall_tick   <= 1'b0;
      change_tick <= 1'b0;
      sample_tick <= 1'b0;
    end else begin
      fall_tick   <= 1'b0;
      change_tick <= 1'b0;
      sample_tick <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state     <= ST_LOW_A;
            cnt       <= '0;
            div_q     <= div;
            scl_oe    <= 1'b1;
            fall_tick <= 1'b1;
          end
        end
        ST_LOW_A: begin
          if (cnt_done) begin
            state       <= ST_LOW_B;
            cnt         <= '0;
            change_tick <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_LOW_B: begin
          if (cnt_done) begin
            state       <= ST_HIGH_A;
            cnt         <= '0;
            scl_oe      <= 1'b0;
            high_seen   <= 1'b0;
            stretch_cnt <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_HIGH_A: begin
          if (stretch_timeout) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (stretching) begin
            // cnt is held while the bus is low; the stretch counter saturates.
            if (stretch_cnt != '1) begin
              stretch_cnt <= stretch_cnt + ST_ONE;
            end
          end else begin
            // The rise cycle itself is count 0 of the high quarter.
            high_seen <= 1'b1;
            if (cnt_done) begin
              state       <= ST_HIGH_B;
              cnt         <= '0;
              sample_tick <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        ST_HIGH_B: begin
          // A low bus before the quarter ends means another master started
          // its low phase; follow it at once so the clocks stay aligned.
          if (cnt_done || !scl_sync) begin
            cnt <= '0;
            if (enable) begin
              state     <= ST_LOW_A;
              div_q     <= div;
              scl_oe    <= 1'b1;
              fall_tick <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state  <= ST_IDLE;
          cnt    <= '0;
          scl_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_scl_gen.sv
`timescale 1ns/1ps
module tb_i2c_scl_gen;

  localparam int DIV_W = 16;

  localparam int K_FALL = 0;
  localparam int K_CHG  = 1;
  localparam int K_RISE = 2;
  localparam int K_SAMP = 3;
  localparam int K_TMO  = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic             ext_low = 1'b0;
  logic [DIV_W-1:0] div = '0;
  logic             scl_in;
  logic             scl_oe;
  logic             fall_tick;
  logic             change_tick;
  logic             rise_tick;
  logic             sample_tick;
  logic             stretching;
  logic             stretch_timeout;
  logic             busy;

  // Open-drain bus with an ideal pull-up; ext_low models a slave or another master.
  assign scl_in = ~scl_oe & ~ext_low;

  i2c_scl_gen #(
    .DIV_W       (DIV_W),
    .SYNC_STAGES (2),
    .STRETCH_MAX (100)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .div             (div),
    .scl_in          (scl_in),
    .scl_oe          (scl_oe),
    .fall_tick       (fall_tick),
    .change_tick     (change_tick),
    .rise_tick       (rise_tick),
    .sample_tick     (sample_tick),
    .stretching      (stretching),
    .stretch_timeout (stretch_timeout),
    .busy            (busy)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int kind;
    int delta;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int delta);
    exp_t e;
    e.kind  = kind;
    e.delta = delta;
    sb.push_back(e);
  endtask

  // Offsets are cycles after the most recent fall_tick (or after the last
  // idle cycle, so the first fall of a run is expected at offset 1).
  task automatic push_period(input int c, input int r, input int s, input int f);
    push(K_CHG, c);
    push(K_RISE, r);
    push(K_SAMP, s);
    if (f > 0) push(K_FALL, f);
  endtask

  task automatic see(input int kind, input int delta);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL tick: unexpected kind %0d at offset %0d, none expected", kind, delta);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.delta != delta) begin
        errors++;
        $display("FAIL tick: got kind %0d at offset %0d, expected kind %0d at offset %0d",
                 kind, delta, e.kind, e.delta);
      end
    end
  endtask

  task automatic monitor();
    int cyc;
    int last_ref;
    cyc = 0;
    last_ref = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (fall_tick) begin
          see(K_FALL, cyc - last_ref);
          last_ref = cyc;
        end
        if (change_tick)     see(K_CHG,  cyc - last_ref);
        if (rise_tick)       see(K_RISE, cyc - last_ref);
        if (sample_tick)     see(K_SAMP, cyc - last_ref);
        if (stretch_timeout) see(K_TMO,  cyc - last_ref);
        if (!busy) last_ref = cyc;
      end else begin
        last_ref = cyc;
      end
    end
  endtask

  // what: 0 fall, 1 change, 2 sample, 3 timeout, 4 scl_oe low, 5 idle
  task automatic wait_for(input int what, input int budget, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      case (what)
        0:       hit = fall_tick;
        1:       hit = change_tick;
        2:       hit = sample_tick;
        3:       hit = stretch_timeout;
        4:       hit = !scl_oe;
        5:       hit = !busy;
        default: hit = 1'b1;
      endcase
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL wait %s: event absent after %0d cycles, expected within budget", name, budget);
    end
  endtask

  task automatic finish_test(input string name);
    wait_for(5, 400, name);
    repeat (30) @(negedge clk);
    chk({name, " pending ticks"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic run_tests();
    int n;
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset scl_oe", scl_oe, 0);
    chk("reset busy", busy, 0);
    chk("reset ticks", {fall_tick, change_tick, rise_tick, sample_tick, stretch_timeout}, 0);
    chk("reset stretching", stretching, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: div=4 free-running, period 22
    div = 16'd4;
    push(K_FALL, 1);
    for (int p = 0; p < 3; p++) push_period(5, 12, 17, 22);
    push_period(5, 12, 17, 0);
    enable = 1'b1;
    wait_for(0, 10, "t1 first fall");
    n = 0;
    for (int i = 0; i < 22; i++) begin
      if (scl_oe) n++;
      @(negedge clk);
    end
    chk("t1 scl_oe low cycles", n, 10);
    wait_for(0, 30, "t1 fall3");
    wait_for(0, 30, "t1 fall4");
    enable = 1'b0;
    finish_test("t1");

    // 2: div=0, period 6
    div = 16'd0;
    push(K_FALL, 1);
    for (int p = 0; p < 2; p++) push_period(1, 4, 5, 6);
    push_period(1, 4, 5, 0);
    enable = 1'b1;
    for (int k = 0; k < 3; k++) wait_for(0, 10, "t2 fall");
    enable = 1'b0;
    finish_test("t2");

    // 3: slave stretches 50 cycles, period 72
    div = 16'd4;
    push(K_FALL, 1);
    push_period(5, 62, 67, 72);
    push_period(5, 12, 17, 0);
    enable = 1'b1;
    wait_for(1, 20, "t3 change");
    ext_low = 1'b1;
    wait_for(4, 20, "t3 release");
    n = 0;
    for (int i = 0; i < 61; i++) begin
      if (stretching) n++;
      if (i == 50) ext_low = 1'b0;
      @(negedge clk);
    end
    chk("t3 stretching cycles", n, 52);
    wait_for(0, 10, "t3 fall2");
    enable = 1'b0;
    finish_test("t3");

    // 4: SCL held low until timeout
    push(K_FALL, 1);
    push(K_CHG, 5);
    push(K_TMO, 110);
    enable = 1'b1;
    wait_for(1, 20, "t4 change");
    ext_low = 1'b1;
    wait_for(4, 20, "t4 release");
    enable = 1'b0;
    wait_for(3, 200, "t4 timeout");
    @(negedge clk);
    chk("t4 busy after timeout", busy, 0);
    chk("t4 scl_oe after timeout", scl_oe, 0);
    ext_low = 1'b0;
    finish_test("t4");

    // 5: div 4->9 mid-period, enable dropped in LOW_A
    div = 16'd4;
    push(K_FALL, 1);
    push_period(5, 12, 17, 22);
    push_period(10, 22, 32, 42);
    push_period(10, 22, 32, 0);
    enable = 1'b1;
    wait_for(1, 20, "t5 change");
    div = 16'd9;
    wait_for(0, 40, "t5 fall2");
    wait_for(0, 60, "t5 fall3");
    enable = 1'b0;
    finish_test("t5");

    // 6a: external master pulls SCL low 3 cycles into HIGH_B
    push(K_FALL, 1);
    push_period(10, 22, 32, 38);
    push_period(10, 22, 32, 0);
    enable = 1'b1;
    wait_for(2, 60, "t6a sample");
    repeat (3) @(negedge clk);
    ext_low = 1'b1;
    repeat (2) @(negedge clk);
    ext_low = 1'b0;
    wait_for(0, 10, "t6a early fall");
    enable = 1'b0;
    finish_test("t6a");

    // 6b: reset asserted in LOW_B
    div = 16'd4;
    push(K_FALL, 1);
    push(K_CHG, 5);
    enable = 1'b1;
    wait_for(1, 20, "t6b change");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6b scl_oe in reset", scl_oe, 0);
    chk("t6b busy in reset", busy, 0);
    chk("t6b ticks in reset", {fall_tick, change_tick, rise_tick, sample_tick, stretch_timeout}, 0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6b busy after reset", busy, 0);
    chk("t6b pending ticks", sb.size(), 0);
  endtask

  initial begin
    fork
      monitor();
      run_tests();
    join_any
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
